// File: rtl/seg_score_ctrl.sv
// Arbitrated binary-to-BCD front end for the 8-digit seven-segment driver.
// Define SEG_SCORE_CTRL_RR_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module seg_score_ctrl #(
  parameter int BIN_W   = 14,
  parameter int SAT_VAL = 9999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [BIN_W-1:0] bin0,
  input  logic             req1,
  input  logic [BIN_W-1:0] bin1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             cs,
  output logic [31:0]      o_data
);

  localparam int               CNT_W   = $clog2(BIN_W + 1);
  localparam int               WORD_W  = 16 + BIN_W;
  localparam logic [BIN_W-1:0] SAT_LIM = BIN_W'(SAT_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic [BIN_W-1:0]   operand_q, operand_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        o_data_q, o_data_d;

  logic               win;
  logic [BIN_W-1:0]   bin_sel;
  logic [15:0]        bcd_adj;
  logic [WORD_W-1:0]  shift_word;
  logic [15:0]        bcd_next;
  logic [BIN_W-1:0]   operand_next;

`ifdef SEG_SCORE_CTRL_RR_EN
  logic rr_ptr_q, rr_ptr_d;
  logic tie_q, tie_d;

  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = rr_ptr_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end
`else
  always_comb begin
    win = 1'b0;
    if (!req0 && req1) begin
      win = 1'b1;
    end
  end
`endif

  assign bin_sel = win ? bin1 : bin0;

  // Double-dabble step: correct every digit that would overflow past 9 once doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shift_word   = {bcd_adj, operand_q} << 1;
  assign bcd_next     = shift_word[WORD_W-1:BIN_W];
  assign operand_next = shift_word[BIN_W-1:0];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    operand_d = operand_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    o_data_d  = o_data_q;
`ifdef SEG_SCORE_CTRL_RR_EN
    rr_ptr_d  = rr_ptr_q;
    tie_d     = tie_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d   = win;
          operand_d = (bin_sel > SAT_LIM) ? SAT_LIM : bin_sel;
          bcd_d     = '0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
`ifdef SEG_SCORE_CTRL_RR_EN
          tie_d     = req0 && req1;
`endif
        end
      end
      SHIFT: begin
        bcd_d     = bcd_next;
        operand_d = operand_next;
        cnt_d     = cnt_q - CNT_W'(1);
        // The final shift lands directly in the display word so it is stable while cs is high.
        if (cnt_q == CNT_W'(1)) begin
          state_d = WRITE;
          if (grant_q) begin
            o_data_d[31:16] = bcd_next;
          end else begin
            o_data_d[15:0] = bcd_next;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef SEG_SCORE_CTRL_RR_EN
        // Only a contested grant hands priority over; lone requests leave the pointer alone.
        if (tie_q) begin
          rr_ptr_d = ~grant_q;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      operand_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      o_data_q  <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      operand_q <= operand_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      o_data_q  <= o_data_d;
    end
  end

`ifdef SEG_SCORE_CTRL_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
      tie_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      tie_q    <= tie_d;
    end
  end
`endif

  assign cs     = (state_q == WRITE);
  assign busy   = (state_q != IDLE);
  assign ack0   = cs && !grant_q;
  assign ack1   = cs && grant_q;
  assign o_data = o_data_q;

endmodule

// File: tb/tb_seg_score_ctrl.sv
// Self-checking bench for seg_score_ctrl: directed and random updates against a decimal-digit model.
// Tie expectations follow SEG_SCORE_CTRL_RR_EN when the build defines it.
module tb_seg_score_ctrl;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [BIN_W-1:0] bin0 = '0;
  logic [BIN_W-1:0] bin1 = '0;
  logic             ack0, ack1, busy, cs;
  logic [31:0]      o_data;

  int checks = 0;
  int failures = 0;
  logic [15:0] modelHalf [2];
`ifdef SEG_SCORE_CTRL_RR_EN
  logic modelPtr = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_score_ctrl #(.BIN_W(BIN_W), .SAT_VAL(9999)) dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .bin0   (bin0),
    .req1   (req1),
    .bin1   (bin1),
    .ack0   (ack0),
    .ack1   (ack1),
    .busy   (busy),
    .cs     (cs),
    .o_data (o_data)
  );

  // Reference: clamp, then split into decimal digits arithmetically.
  function automatic logic [15:0] bcdOf(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [31:0] expData();
    return {modelHalf[1], modelHalf[0]};
  endfunction

  function automatic logic ackOf(input int which);
    return (which == 0) ? ack0 : ack1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input int which, input logic v);
    if (which == 0) req0 = v;
    else req1 = v;
  endtask

  task automatic setBin(input int which, input int v);
    if (which == 0) bin0 = BIN_W'(v);
    else bin1 = BIN_W'(v);
  endtask

  // Edges are counted from the edge just before req was driven high.
  task automatic waitCs(input int start, output int edges);
    edges = start;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!cs && edges < 60);
    checkOutput("cs_seen", 32'(cs), 32'd1);
  endtask

  task automatic dropReq(input int which);
    @(posedge clk);
    #1 setReq(which, 1'b0);
    @(negedge clk);
    checkOutput("cs_one_cycle", 32'(cs), 32'd0);
    checkOutput("ack_cleared", 32'({ack0, ack1}), 32'd0);
  endtask

  task automatic applyStimulus(input int which, input int val);
    int edges;
    @(posedge clk);
    #1;
    setBin(which, val);
    setReq(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("busy_in_shift", 32'(busy), 32'd1);
    checkOutput("cs_early", 32'(cs), 32'd0);
    waitCs(1, edges);
    modelHalf[which] = bcdOf(val);
    checkOutput("latency", 32'(edges), 32'(BIN_W + 1));
    checkOutput($sformatf("ack%0d", which), 32'(ackOf(which)), 32'd1);
    checkOutput("ack_other", 32'(ackOf(1 - which)), 32'd0);
    checkOutput($sformatf("o_data_val%0d", val), o_data, expData());
    dropReq(which);
    checkOutput("idle_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic tieStep(input int round);
    int win;
    int edges;
    int gap;
`ifdef SEG_SCORE_CTRL_RR_EN
    win = int'(modelPtr);
    modelPtr = ~modelPtr;
`else
    win = 0;
`endif
    @(posedge clk);
    #1;
    bin0 = BIN_W'(11);
    bin1 = BIN_W'(22);
    req0 = 1'b1;
    req1 = 1'b1;
    waitCs(0, edges);
    modelHalf[win] = bcdOf((win == 0) ? 11 : 22);
    checkOutput($sformatf("tie%0d_winner_ack", round), 32'(ackOf(win)), 32'd1);
    checkOutput($sformatf("tie%0d_loser_wait", round), 32'(ackOf(1 - win)), 32'd0);
    checkOutput($sformatf("tie%0d_first_data", round), o_data, expData());
    @(posedge clk);
    #1 setReq(win, 1'b0);
    waitCs(1, gap);
    modelHalf[1 - win] = bcdOf((win == 0) ? 22 : 11);
    checkOutput($sformatf("tie%0d_gap", round), 32'(gap), 32'(BIN_W + 2));
    checkOutput($sformatf("tie%0d_loser_ack", round), 32'(ackOf(1 - win)), 32'd1);
    checkOutput($sformatf("tie%0d_final_data", round), o_data, expData());
    dropReq(1 - win);
  endtask

  initial begin
    int edges;
    modelHalf[0] = 16'h0000;
    modelHalf[1] = 16'h0000;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_o_data", o_data, 32'h0000_0000);
    checkOutput("reset_cs", 32'(cs), 32'd0);
    checkOutput("reset_acks", 32'({ack0, ack1}), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    applyStimulus(0, 1234);
    applyStimulus(1, 56);
    applyStimulus(0, 12000);
    applyStimulus(0, 0);
    applyStimulus(0, 9999);
    applyStimulus(1, 10000);
    applyStimulus(1, 16383);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 16383)));
    end

    tieStep(1);
    tieStep(2);

    // Reset in the middle of a conversion must abort it silently.
    @(posedge clk);
    #1;
    bin0 = BIN_W'(777);
    req0 = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    modelHalf[0] = 16'h0000;
    modelHalf[1] = 16'h0000;
    checkOutput("midreset_o_data", o_data, expData());
    checkOutput("midreset_cs", 32'(cs), 32'd0);
    checkOutput("midreset_ack0", 32'(ack0), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_held_ack0", 32'(ack0), 32'd0);
    reset = 1'b0;
    waitCs(0, edges);
    modelHalf[0] = bcdOf(777);
    checkOutput("after_reset_latency", 32'(edges), 32'(BIN_W + 1));
    checkOutput("after_reset_ack0", 32'(ack0), 32'd1);
    checkOutput("after_reset_o_data", o_data, expData());
    dropReq(0);

    // Operand must be captured at grant, not tracked afterwards.
    @(posedge clk);
    #1;
    bin0 = BIN_W'(300);
    req0 = 1'b1;
    repeat (4) @(posedge clk);
    #1 bin0 = BIN_W'(400);
    waitCs(4, edges);
    modelHalf[0] = bcdOf(300);
    checkOutput("bin_change_latency", 32'(edges), 32'(BIN_W + 1));
    checkOutput("bin_change_o_data", o_data, expData());
    dropReq(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
